// File: rtl/clm_inverse_seq_pkg.sv
// Shared types for the CLM-masked GF(2^8) inversion stage: encoded state, reduction randomness, fold matrix, FSM states.
// An encoded value is any polynomial congruent to the plain byte modulo the AES polynomial, carried in 8+CLM_D bits.
package clm_inverse_seq_pkg;

    localparam int CLM_D = 2;
    localparam int CLM_W = 8 + CLM_D;
    localparam logic [8:0] AES_POLY = 9'h11B;

    typedef logic [CLM_W-1:0]            state_t;
    typedef logic [CLM_D-1:0]            red_poly_t;
    // Row i folds product bit CLM_W+i back into the CLM_W-bit window.
    typedef logic [CLM_W-2:0][CLM_W-1:0] mul_m_matrix_t;

    typedef enum logic [3:0] {
        IDLE, SQ1, MUL1, SQ4A, MUL2, SQ4B, SQ4C, MUL3, MUL4, DONE
    } clm_inv_state_t;

    // r(x)*P(x): a fresh multiple of the field polynomial, invisible after decoding.
    function automatic state_t rand_multiple(red_poly_t r);
        state_t res;
        res = '0;
        for (int i = 0; i < CLM_D; i++) begin
            if (r[i]) res ^= state_t'(AES_POLY) << i;
        end
        return res;
    endfunction

endpackage

// File: rtl/clm_inverse_seq_if.sv
// Operand, randomness and result channels of the inversion stage, plus the quasi-static fold matrix.
interface clm_inverse_seq_if;
    import clm_inverse_seq_pkg::*;

    logic          in_valid;
    logic          in_ready;
    state_t        in_data;
    logic          rnd_valid;
    logic          rnd_ready;
    red_poly_t     rnd;
    mul_m_matrix_t B_ext;
    logic          out_valid;
    logic          out_ready;
    state_t        out_data;

    modport master (
        output in_valid, in_data, rnd_valid, rnd, B_ext, out_ready,
        input  in_ready, rnd_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rnd_valid, rnd, B_ext, out_ready,
        output in_ready, rnd_ready, out_valid, out_data
    );

endinterface

// File: rtl/clm_inverse_seq_mul_reduce.sv
// Combinational carry-less multiply of two encoded operands, folded back to CLM_W bits via B_ext plus r*P re-masking.
// Zero latency; no handshake.
module clm_mul_reduce
    import clm_inverse_seq_pkg::*;
(
    input  state_t        a,
    input  state_t        b,
    input  red_poly_t     r,
    input  mul_m_matrix_t B_ext,
    output state_t        y
);

    logic [2*CLM_W-2:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < CLM_W; i++) begin
            if (b[i]) prod ^= {{(CLM_W-1){1'b0}}, a} << i;
        end
        y = prod[CLM_W-1:0] ^ rand_multiple(r);
        for (int i = 0; i < CLM_W-1; i++) begin
            if (prod[CLM_W+i]) y ^= B_ext[i];
        end
    end

endmodule

// File: rtl/clm_inverse_seq_square.sv
// Encoded squaring primitive: n_sq = 1 gives a^2, n_sq = 2 gives a^4 (two chained squarings sharing r).
// Zero latency; no handshake.
module clm_square
    import clm_inverse_seq_pkg::*;
#(
    parameter int n_sq = 1
) (
    input  state_t        a,
    input  red_poly_t     r,
    input  mul_m_matrix_t B_ext,
    output state_t        y
);

    if (n_sq == 1) begin : g_one
        clm_mul_reduce u_sq (.a(a), .b(a), .r(r), .B_ext(B_ext), .y(y));
    end else begin : g_two
        state_t mid;
        clm_mul_reduce u_sq0 (.a(a),   .b(a),   .r(r), .B_ext(B_ext), .y(mid));
        clm_mul_reduce u_sq1 (.a(mid), .b(mid), .r(r), .B_ext(B_ext), .y(y));
    end

endmodule

// File: rtl/clm_inverse_seq.sv
// Sequential x^254 over CLM-encoded GF(2^8): 8 steps after accept, DONE holds until out_ready; no overlap.
// CLM_FRESH_RAND_EN: fresh r per step (steps stall on rnd_valid); otherwise r latched at accept and reused.
module clm_inverse_seq
    import clm_inverse_seq_pkg::*;
#(
    parameter int d = CLM_D
) (
    input logic               clk,
    input logic               rst_n,
    clm_inverse_seq_if.slave  bus
);

    if (d != CLM_D) begin : g_bad_d
        $error("clm_inverse_seq: d must match the package masking order");
    end

    clm_inv_state_t state, state_nxt;
    state_t         x_q, t2_q, t3_q, t12_q, acc_q;
    state_t         sq1_in, sq4_in, mul_a, mul_b;
    state_t         sq1_out, sq4_out, mul_out;
    red_poly_t      r_use;
    logic           is_step, accept, advance;

`ifdef CLM_FRESH_RAND_EN
    assign r_use = bus.rnd;
`else
    red_poly_t r_q;
    assign r_use = r_q;
`endif

    assign is_step      = (state != IDLE) && (state != DONE);
    assign bus.out_data = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
`ifdef CLM_FRESH_RAND_EN
        accept        = (state == IDLE) && bus.in_valid;
        advance       = is_step && bus.rnd_valid;
        bus.rnd_ready = advance;
`else
        accept        = (state == IDLE) && bus.in_valid && bus.rnd_valid;
        advance       = is_step;
        bus.rnd_ready = accept;
`endif
        case (state)
            IDLE:    if (accept)        state_nxt = SQ1;
            SQ1:     if (advance)       state_nxt = MUL1;
            MUL1:    if (advance)       state_nxt = SQ4A;
            SQ4A:    if (advance)       state_nxt = MUL2;
            MUL2:    if (advance)       state_nxt = SQ4B;
            SQ4B:    if (advance)       state_nxt = SQ4C;
            SQ4C:    if (advance)       state_nxt = MUL3;
            MUL3:    if (advance)       state_nxt = MUL4;
            MUL4:    if (advance)       state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operand selection: one squarer pair and one multiplier shared across the chain.
    always_comb begin
        sq1_in = x_q;
        sq4_in = (state == SQ4A) ? t3_q : acc_q;
        mul_a  = acc_q;
        mul_b  = t2_q;
        case (state)
            MUL1:    begin mul_a = t2_q;  mul_b = x_q;   end
            MUL2:    begin mul_a = t12_q; mul_b = t3_q;  end
            MUL3:    begin mul_a = acc_q; mul_b = t12_q; end
            default: begin mul_a = acc_q; mul_b = t2_q;  end
        endcase
    end

    clm_square #(.n_sq(1)) u_sq1 (.a(sq1_in), .r(r_use), .B_ext(bus.B_ext), .y(sq1_out));
    clm_square #(.n_sq(2)) u_sq4 (.a(sq4_in), .r(r_use), .B_ext(bus.B_ext), .y(sq4_out));
    clm_mul_reduce         u_mul (.a(mul_a), .b(mul_b), .r(r_use), .B_ext(bus.B_ext), .y(mul_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            t2_q  <= '0;
            t3_q  <= '0;
            t12_q <= '0;
            acc_q <= '0;
`ifndef CLM_FRESH_RAND_EN
            r_q   <= '0;
`endif
        end else begin
            if (accept) begin
                x_q <= bus.in_data;
`ifndef CLM_FRESH_RAND_EN
                r_q <= bus.rnd;
`endif
            end
            if (advance) begin
                case (state)
                    SQ1:               t2_q  <= sq1_out;
                    MUL1:              t3_q  <= mul_out;
                    SQ4A:              t12_q <= sq4_out;
                    SQ4B, SQ4C:        acc_q <= sq4_out;
                    MUL2, MUL3, MUL4:  acc_q <= mul_out;
                    default:           ;
                endcase
            end
        end
    end

endmodule
